// File: rtl/adc_capture.sv
// ADC sample capture: decimates a registered ADC stream, buffers it in a RAM FIFO and
// feeds a byte-wide serial transmitter, either continuously or as a triggered burst.
module adc_capture #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk12,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] adc_d,
    input  logic [7:0]        decim,
    input  logic              mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              start,
    input  logic              stop,
    output logic [7:0]        tx_byte,
    output logic              tx_rdy,
    input  logic              tx_done,
    output logic [2:0]        state,
    output logic              overflow,
    output logic              done
);

    localparam int   AW   = $clog2(DEPTH);
    localparam logic WIDE = (DATA_W > 8);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STREAM  = 3'd1,
        S_ARM     = 3'd2,
        S_CAPTURE = 3'd3,
        S_DUMP    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] adc_q;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [7:0]        dec_cnt_q, dec_cnt_d;
    logic [7:0]        decim_q, decim_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              stopping_q, stopping_d;
    logic              pend_q, pend_d;
    logic              phase_q, phase_d;
    logic              tx_idle_q, tx_idle_d;
    logic              tx_rdy_q, tx_rdy_d;
    logic              done_q, done_d;
    logic [7:0]        tx_byte_q, tx_byte_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              keep;
    logic              wr_en;
    logic              rd_en;
    logic              clr;
    logic [15:0]       samp16;

    assign keep   = (dec_cnt_q == decim_q);
    assign samp16 = 16'(rd_data_q);

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        dec_cnt_d  = keep ? 8'd0 : dec_cnt_q + 8'd1;
        decim_d    = keep ? decim : decim_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        stopping_d = stopping_q;
        pend_d     = pend_q;
        phase_d    = phase_q;
        tx_idle_d  = tx_idle_q;
        tx_rdy_d   = 1'b0;
        done_d     = 1'b0;
        tx_byte_d  = tx_byte_q;
        wr_en      = 1'b0;
        clr        = 1'b0;

        // rd_data_q holds the pending sample, so a new read waits until it is fully sent
        rd_en = ((state_q == S_STREAM) || (state_q == S_DUMP)) && !pend_q && (count_q != '0);

        if (!tx_idle_q && tx_done) begin
            tx_idle_d = 1'b1;
        end

        if (rd_en) begin
            pend_d  = 1'b1;
            phase_d = WIDE;
        end else if (pend_q && tx_idle_q) begin
            tx_rdy_d  = 1'b1;
            tx_idle_d = 1'b0;
            tx_byte_d = phase_q ? samp16[15:8] : samp16[7:0];
            if (phase_q) begin
                phase_d = 1'b0;
            end else begin
                pend_d = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = mode ? S_ARM : S_STREAM;
                    dec_cnt_d  = 8'd0;
                    decim_d    = decim;
                    prev_d     = '0;
                    overflow_d = 1'b0;
                    stopping_d = 1'b0;
                    pend_d     = 1'b0;
                    phase_d    = 1'b0;
                    clr        = 1'b1;
                end
            end
            S_STREAM: begin
                if (stop || stopping_q) begin
                    stopping_d = 1'b1;
                    if ((count_q == '0) && !pend_q && tx_idle_q) begin
                        state_d = S_IDLE;
                    end
                end else if (keep) begin
                    if (count_q == (AW+1)'(DEPTH)) begin
                        overflow_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            S_ARM: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (keep) begin
                    prev_d = adc_q;
                    if ((prev_q < trig_level) && (adc_q >= trig_level)) begin
                        wr_en   = 1'b1;
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (keep) begin
                    wr_en = 1'b1;
                    if (count_q == (AW+1)'(DEPTH - 1)) begin
                        state_d = S_DUMP;
                    end
                end
            end
            S_DUMP: begin
                if ((count_q == '0) && !pend_q && tx_idle_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            adc_q      <= '0;
            prev_q     <= '0;
            dec_cnt_q  <= 8'd0;
            decim_q    <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            stopping_q <= 1'b0;
            pend_q     <= 1'b0;
            phase_q    <= 1'b0;
            tx_idle_q  <= 1'b1;
            tx_rdy_q   <= 1'b0;
            done_q     <= 1'b0;
            tx_byte_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            adc_q      <= adc_d;
            prev_q     <= prev_d;
            dec_cnt_q  <= dec_cnt_d;
            decim_q    <= decim_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            stopping_q <= stopping_d;
            pend_q     <= pend_d;
            phase_q    <= phase_d;
            tx_idle_q  <= tx_idle_d;
            tx_rdy_q   <= tx_rdy_d;
            done_q     <= done_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    // Sample RAM: no reset so it maps onto block RAM; read data is registered.
    always_ff @(posedge clk12) begin
        if (wr_en) mem[wr_ptr_q] <= adc_q;
        if (rd_en) rd_data_q <= mem[rd_ptr_q];
    end

    assign tx_byte  = tx_byte_q;
    assign tx_rdy   = tx_rdy_q;
    assign state    = state_q;
    assign overflow = overflow_q;
    assign done     = done_q;

endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: an 8-bit/16-deep instance and a 12-bit/4-deep instance,
// each with its own transmitter responder, checked against a kept-sample schedule model.
module tb_adc_capture;

    logic clk12 = 1'b0;
    always #5 clk12 = ~clk12;
    logic rst_n;

    logic [7:0]  a_adc, a_trig, a_decim, a_txbyte;
    logic        a_mode, a_start, a_stop, a_txrdy, a_ovf, a_done;
    logic        a_txdone = 1'b0;
    logic [2:0]  a_state;

    logic [11:0] b_adc, b_trig;
    logic [7:0]  b_decim, b_txbyte;
    logic        b_mode, b_start, b_stop, b_txrdy, b_ovf, b_done;
    logic        b_txdone = 1'b0;
    logic [2:0]  b_state;

    adc_capture #(.DATA_W(8), .DEPTH(16)) u_a (
        .clk12(clk12), .rst_n(rst_n), .adc_d(a_adc), .decim(a_decim), .mode(a_mode),
        .trig_level(a_trig), .start(a_start), .stop(a_stop), .tx_byte(a_txbyte),
        .tx_rdy(a_txrdy), .tx_done(a_txdone), .state(a_state), .overflow(a_ovf), .done(a_done)
    );

    adc_capture #(.DATA_W(12), .DEPTH(4)) u_b (
        .clk12(clk12), .rst_n(rst_n), .adc_d(b_adc), .decim(b_decim), .mode(b_mode),
        .trig_level(b_trig), .start(b_start), .stop(b_stop), .tx_byte(b_txbyte),
        .tx_rdy(b_txrdy), .tx_done(b_txdone), .state(b_state), .overflow(b_ovf), .done(b_done)
    );

    int checks = 0;
    int errors = 0;

    // Transmitter models: record each byte, answer tx_done two cycles after tx_rdy when enabled.
    logic [7:0] a_rx[$];
    logic [7:0] b_rx[$];
    int a_rdy_cnt = 0, a_done_cnt = 0, a_cd = 0;
    int b_rdy_cnt = 0, b_done_cnt = 0, b_cd = 0;
    bit a_out = 1'b0, b_out = 1'b0;
    bit a_auto = 1'b1, b_auto = 1'b1;

    always @(negedge clk12) begin
        a_txdone = 1'b0;
        if (a_cd > 0) a_cd--;
        if (a_out && a_auto && a_cd == 0) begin a_txdone = 1'b1; a_out = 1'b0; end
        if (a_txrdy === 1'b1) begin a_rx.push_back(a_txbyte); a_rdy_cnt++; a_out = 1'b1; a_cd = 2; end
        if (a_done === 1'b1) a_done_cnt++;
    end

    always @(negedge clk12) begin
        b_txdone = 1'b0;
        if (b_cd > 0) b_cd--;
        if (b_out && b_auto && b_cd == 0) begin b_txdone = 1'b1; b_out = 1'b0; end
        if (b_txrdy === 1'b1) begin b_rx.push_back(b_txbyte); b_rdy_cnt++; b_out = 1'b1; b_cd = 2; end
        if (b_done === 1'b1) b_done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] a_byte(input int idx);
        if (idx < a_rx.size()) return {24'h0, a_rx[idx]};
        return 32'hDEAD;
    endfunction

    function automatic logic [31:0] b_byte(input int idx);
        if (idx < b_rx.size()) return {24'h0, b_rx[idx]};
        return 32'hDEAD;
    endfunction

    task automatic tick();
        @(posedge clk12);
        #1;
    endtask

    task automatic wait_idle(input bit use_b, input string name);
        int t = 0;
        while (((use_b ? b_state : a_state) !== 3'd0) && t < 3000) begin tick(); t++; end
        chk(name, {29'h0, use_b ? b_state : a_state}, 32'd0);
    endtask

    // Stream on A: sample kept at edge k (k = multiples of d+1 after the start edge) carries
    // the value driven before edge k-1; the stop edge itself keeps nothing.
    task automatic a_stream_run(input int d, input int n, input bit ramp, input string tag);
        logic [7:0] val[$];
        logic [7:0] exp_q[$];
        int rb;
        rb = a_rx.size();
        a_mode = 1'b0;
        a_decim = d[7:0];
        for (int i = 0; i < n; i++) begin
            val.push_back(ramp ? 8'(i) : 8'($urandom));
            a_adc = val[i];
            a_start = (i == 0);
            tick();
        end
        a_start = 1'b0;
        a_stop = 1'b1;
        tick();
        a_stop = 1'b0;
        for (int k = d + 1; k < n; k += d + 1) exp_q.push_back(val[k-1]);
        wait_idle(1'b0, {tag, " idle"});
        chk({tag, " count"}, a_rx.size() - rb, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s byte%0d", tag, i), a_byte(rb + i), {24'h0, exp_q[i]});
        chk({tag, " overflow"}, {31'h0, a_ovf}, 32'd0);
    endtask

    // Burst on A: walk the kept samples, find the first below->at/above crossing, take 16.
    task automatic a_burst_run(input int d, input int n, input bit step, input bit inject, input string tag);
        logic [7:0] val[$];
        logic [7:0] exp_q[$];
        logic [7:0] prev, cur;
        bit found, injected, just;
        int rb, rc, dc, t;
        rb = a_rx.size(); rc = a_rdy_cnt; dc = a_done_cnt;
        injected = 1'b0;
        a_trig = 8'h80;
        a_decim = d[7:0];
        for (int i = 0; i < n; i++) begin
            val.push_back(step ? ((i < 10) ? 8'h10 : 8'h90) : 8'($urandom));
            a_adc = val[i];
            a_mode = 1'b1;
            a_start = (i == 0);
            a_stop = 1'b0;
            just = 1'b0;
            if (inject && !injected && a_state == 3'd3) begin
                a_start = 1'b1; a_mode = 1'b0; a_stop = 1'b1; injected = 1'b1; just = 1'b1;
            end
            tick();
            if (just) chk({tag, " start/stop in CAPTURE"}, {29'h0, a_state}, 32'd3);
        end
        a_start = 1'b0; a_stop = 1'b0;
        t = 0;
        while (a_done_cnt == dc && t < 3000) begin tick(); t++; end
        repeat (5) tick();
        prev = 8'h00; found = 1'b0;
        for (int k = d + 1; k < n; k += d + 1) begin
            cur = val[k-1];
            if (!found) begin
                if (prev < 8'h80 && cur >= 8'h80) begin found = 1'b1; exp_q.push_back(cur); end
                prev = cur;
            end else if (exp_q.size() < 16) exp_q.push_back(cur);
        end
        chk({tag, " done pulses"}, a_done_cnt - dc, 32'd1);
        chk({tag, " tx_rdy pulses"}, a_rdy_cnt - rc, 32'd16);
        chk({tag, " final state"}, {29'h0, a_state}, 32'd0);
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s byte%0d", tag, i), a_byte(rb + i), {24'h0, exp_q[i]});
    endtask

    typedef struct {
        logic [11:0] samp;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } fmt_vec_t;

    initial begin
        fmt_vec_t tbl[5];
        logic [11:0] bval[$];
        int rb, rc;
        int t;

        tbl[0] = '{12'hABC, 8'h0A, 8'hBC};
        tbl[1] = '{12'h000, 8'h00, 8'h00};
        tbl[2] = '{12'hFFF, 8'h0F, 8'hFF};
        tbl[3] = '{12'h801, 8'h08, 8'h01};
        tbl[4] = '{12'h17F, 8'h01, 8'h7F};

        rst_n = 1'b0;
        a_adc = 0; a_trig = 8'h80; a_decim = 0; a_mode = 0; a_start = 0; a_stop = 0;
        b_adc = 0; b_trig = 12'h800; b_decim = 0; b_mode = 0; b_start = 0; b_stop = 0;
        repeat (3) tick();
        chk("reset a state", {29'h0, a_state}, 32'd0);
        chk("reset a tx_byte", {24'h0, a_txbyte}, 32'd0);
        chk("reset a tx_rdy", {31'h0, a_txrdy}, 32'd0);
        chk("reset a done/ovf", {30'h0, a_done, a_ovf}, 32'd0);
        chk("reset b state", {29'h0, b_state}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 35: ramp with decim=3 gives 3,7,11,...
        rb = a_rx.size();
        a_stream_run(3, 41, 1'b1, "ramp");
        chk("ramp first byte", a_byte(rb), 32'd3);

        for (int r = 0; r < 4; r++)
            a_stream_run($urandom_range(4, 9), $urandom_range(30, 80), 1'b0, $sformatf("rstream%0d", r));

        // 37 + 39b: step burst, with start/stop injected during CAPTURE
        rb = a_rx.size();
        a_burst_run(0, 60, 1'b1, 1'b1, "step burst");
        chk("step burst first", a_byte(rb), 32'h90);
        for (int r = 0; r < 2; r++)
            a_burst_run($urandom_range(0, 3), 300, 1'b0, 1'b0, $sformatf("rburst%0d", r));

        // 39a: ARM without a crossing, then stop
        rc = a_rdy_cnt;
        a_mode = 1'b1; a_decim = 0; a_adc = 8'h10; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (20) tick();
        chk("arm waiting", {29'h0, a_state}, 32'd2);
        a_stop = 1'b1;
        tick();
        a_stop = 1'b0;
        chk("arm stop idle", {29'h0, a_state}, 32'd0);
        repeat (5) tick();
        chk("arm stop no tx", a_rdy_cnt - rc, 32'd0);

        // 40: asynchronous reset in DUMP
        rc = a_rdy_cnt;
        a_mode = 1'b1; a_adc = 8'h10; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (5) tick();
        a_adc = 8'h90;
        t = 0;
        while (!(a_state == 3'd4 && a_rdy_cnt - rc >= 2) && t < 500) begin tick(); t++; end
        chk("reach dump", {29'h0, a_state}, 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst state", {29'h0, a_state}, 32'd0);
        chk("async rst tx_byte", {24'h0, a_txbyte}, 32'd0);
        chk("async rst rdy/done/ovf", {29'h0, a_txrdy, a_done, a_ovf}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        rc = a_rdy_cnt;
        repeat (40) tick();
        chk("post rst no tx", a_rdy_cnt - rc, 32'd0);
        chk("post rst state", {29'h0, a_state}, 32'd0);

        // 38: 12-bit byte formatting, one sample per run
        for (int v = 0; v < 5; v++) begin
            rb = b_rx.size(); rc = b_rdy_cnt;
            b_mode = 1'b0; b_decim = 0;
            b_adc = tbl[v].samp; b_start = 1'b1;
            tick();
            b_start = 1'b0; b_adc = ~tbl[v].samp;
            tick();
            b_stop = 1'b1;
            tick();
            b_stop = 1'b0;
            wait_idle(1'b1, $sformatf("fmt%0d idle", v));
            chk($sformatf("fmt%0d rdy count", v), b_rdy_cnt - rc, 32'd2);
            chk($sformatf("fmt%0d hi", v), b_byte(rb), {24'h0, tbl[v].hi});
            chk($sformatf("fmt%0d lo", v), b_byte(rb + 1), {24'h0, tbl[v].lo});
        end

        // 36: DEPTH=4, tx_done withheld -> one byte out, four samples held, overflow
        rb = b_rx.size(); rc = b_rdy_cnt;
        b_auto = 1'b0; b_decim = 0; b_mode = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bval.push_back(12'($urandom));
            b_adc = bval[i];
            b_start = (i == 0);
            tick();
        end
        b_start = 1'b0;
        chk("ovf set", {31'h0, b_ovf}, 32'd1);
        chk("ovf one byte sent", b_rdy_cnt - rc, 32'd1);
        chk("ovf first byte", b_byte(rb), {28'h0, bval[0][11:8]});
        b_stop = 1'b1;
        tick();
        b_stop = 1'b0;
        tick();
        chk("ovf stop waits", {29'h0, b_state}, 32'd1);
        b_auto = 1'b1;
        wait_idle(1'b1, "ovf drain idle");
        chk("ovf drain count", b_rx.size() - rb, 32'd10);
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("ovf s%0d hi", s), b_byte(rb + 2*s), {28'h0, bval[s][11:8]});
            chk($sformatf("ovf s%0d lo", s), b_byte(rb + 2*s + 1), {24'h0, bval[s][7:0]});
        end
        chk("ovf sticky in idle", {31'h0, b_ovf}, 32'd1);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("ovf cleared by start", {31'h0, b_ovf}, 32'd0);
        b_stop = 1'b1;
        tick();
        b_stop = 1'b0;
        chk("empty stop idle", {29'h0, b_state}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning ADC sample width (1..16).
REQ-002 SHALL have parameter DEPTH, default 256, meaning sample buffer depth (power of 2, 4..4096).
REQ-003 SHALL have port clk12  input  1  sample/system clock; single clock domain.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port adc_d  input  DATA_W  raw ADC sample.
REQ-006 SHALL have port decim  input  8  decimation: keep one sample per decim+1 cycles.
REQ-007 SHALL have port mode  input  1  0 = stream, 1 = triggered burst; sampled on start.
REQ-008 SHALL have port trig_level  input  DATA_W  burst trigger threshold, unsigned.
REQ-009 SHALL have port start  input  1  single-cycle pulse; leaves IDLE.
REQ-010 SHALL have port stop  input  1  single-cycle pulse; ends STREAM or ARM.
REQ-011 SHALL have port tx_byte  output  8  byte to serial transmitter.
REQ-012 SHALL have port tx_rdy  output  1  single-cycle pulse; tx_byte valid.
REQ-013 SHALL have port tx_done  input  1  single-cycle pulse from transmitter (end of send).
REQ-014 SHALL have port state  output  3  current state encoding.
REQ-015 SHALL have port overflow  output  1  sticky; stream sample dropped.
REQ-016 SHALL have port done  output  1  single-cycle pulse; burst dump finished.

Function
REQ-017 SHALL register adc_d once before use (1-cycle input latency).
REQ-018 SHALL run decimation counter 0..decim, wrapping to 0; a sample is kept on the cycle count==decim; decim=0 keeps every sample; decim change takes effect at next wrap.
REQ-019 SHALL implement states IDLE=0, STREAM=1, ARM=2, CAPTURE=3, DUMP=4; other codes SHALL return to IDLE next cycle.
REQ-020 SHALL in IDLE on start go to STREAM (mode=0) or ARM (mode=1), clearing decimation counter, buffer pointers and overflow.
REQ-021 SHALL in STREAM write each kept sample to the buffer (FIFO); if buffer full, drop sample and set overflow.
REQ-022 SHALL in STREAM on stop cease writing and go to IDLE once buffer empty and transmitter idle.
REQ-023 SHALL in ARM detect trigger as previous kept sample < trig_level AND current kept sample >= trig_level; trigger sample is first sample written; go to CAPTURE.
REQ-024 SHALL in ARM on stop go to IDLE with no output.
REQ-025 SHALL in CAPTURE write kept samples until DEPTH written, then go to DUMP; stop ignored; no bytes sent during CAPTURE.
REQ-026 SHALL in DUMP send all DEPTH samples in write order, then pulse done and go to IDLE; stop ignored.
REQ-027 SHALL ignore start outside IDLE.
REQ-028 SHALL format each sample: DATA_W<=8 -> one byte, zero-extended; DATA_W 9..16 -> two bytes, high byte first, zero-extended.
REQ-029 SHALL keep internal tx_idle flag: set at reset, cleared on tx_rdy, set on tx_done; tx_rdy only asserted when tx_idle=1 and a byte is pending.
REQ-030 SHALL assert tx_rdy the cycle after a byte becomes pending with tx_idle=1; tx_byte SHALL stay stable from tx_rdy until next tx_rdy.
REQ-031 SHALL treat simultaneous write and read on buffer as valid (count unchanged); full = DEPTH entries, pointers wrap modulo DEPTH.
REQ-032 SHALL ignore tx_done when tx_idle=1.

Reset
REQ-033 SHALL on rst_n=0 immediately force: state=IDLE, tx_byte=0, tx_rdy=0, done=0, overflow=0, pointers/count=0, decimation counter=0, tx_idle=1, previous-sample register=0.
REQ-034 SHALL on reset mid-operation discard buffered data; no tx_rdy until a new start.

Verification
REQ-035 Stream, DATA_W=8, decim=3, adc_d ramp 0,1,2..., tx_done 2 cycles after each tx_rdy -> tx_byte sequence 3,7,11,... (ramp value at kept cycle, offset by input register), no overflow.
REQ-036 Stream, decim=0, tx_done withheld, DEPTH=4 -> 4 samples buffered, 1 sent, further samples dropped, overflow=1 until next start.
REQ-037 Burst, trig_level=0x80, adc_d 0x10 then 0x90 step, DEPTH=16 -> first tx_byte=0x90, exactly 16 tx_rdy pulses, then done pulse, state=0.
REQ-038 DATA_W=12, sample 0xABC -> tx_byte 0x0A then 0xBC, each with own tx_rdy/tx_done.
REQ-039 ARM with no crossing, stop pulse -> state IDLE next cycle, zero tx_rdy; start during CAPTURE -> ignored.
REQ-040 rst_n low during DUMP -> all outputs zero asynchronously, state=0; no tx_rdy after release until start.
